// File: rtl/tcb_arbiter.sv
// tcb_arbiter: round-robin arbiter that shares one TCB subordinate between
// MN TCB managers. One transfer per cycle is issued to the subordinate and
// each response is routed back to the manager that issued it, DLY cycles
// later.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   mng_vld/wen/adr/wdt per-manager request (packed per manager)
//   mng_rdy, mng_err    per-manager ready / error response
//   mng_rdt             read data, broadcast to every manager
//   sub_vld/wen/adr/wdt shared request towards the subordinate
//   sub_rdy/rdt/err     subordinate ready / read data / error
module tcb_arbiter #(
    parameter int MN  = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int DLY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [MN-1:0]          mng_vld,
    input  logic [MN-1:0]          mng_wen,
    input  logic [MN-1:0][AW-1:0]  mng_adr,
    input  logic [MN-1:0][DW-1:0]  mng_wdt,
    output logic [MN-1:0]          mng_rdy,
    output logic [DW-1:0]          mng_rdt,
    output logic [MN-1:0]          mng_err,
    output logic                   sub_vld,
    output logic                   sub_wen,
    output logic [AW-1:0]          sub_adr,
    output logic [DW-1:0]          sub_wdt,
    input  logic                   sub_rdy,
    input  logic [DW-1:0]          sub_rdt,
    input  logic                   sub_err
);

    localparam int IW = (MN > 1) ? $clog2(MN) : 1;

    if (MN < 2) begin : g_chk_mn
        $error("tcb_arbiter: MN must be at least 2");
    end
    if (DLY > 4) begin : g_chk_dly
        $error("tcb_arbiter: DLY must be at most 4");
    end

    logic [IW-1:0] r_ptr;      // highest-priority index for the next grant
    logic          r_lck;      // a stalled request owns the bus
    logic [IW-1:0] r_lck_idx;

    logic [IW-1:0] w_gnt;
    logic [IW-1:0] w_idx;
    logic          w_xfer;
    logic          w_out_vld;
    logic [IW-1:0] w_out_idx;

    // Scan from the lowest priority upwards so the first requester in
    // ptr, ptr+1, ... order is the last one written and wins.
    always_comb begin
        w_gnt = r_ptr;
        w_idx = '0;
        if (r_lck) begin
            w_gnt = r_lck_idx;
        end else begin
            for (int k = MN - 1; k >= 0; k--) begin
                w_idx = IW'((int'(r_ptr) + k) % MN);
                if (mng_vld[w_idx]) w_gnt = w_idx;
            end
        end
    end

    assign sub_vld = |mng_vld;
    assign w_xfer  = sub_vld & sub_rdy;
    assign mng_rdt = sub_rdt;

    // Idle bus drives zeros so nothing floats to X downstream.
    always_comb begin
        sub_wen = 1'b0;
        sub_adr = '0;
        sub_wdt = '0;
        if (sub_vld) begin
            sub_wen = mng_wen[w_gnt];
            sub_adr = mng_adr[w_gnt];
            sub_wdt = mng_wdt[w_gnt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_lck     <= 1'b0;
            r_lck_idx <= '0;
        end else begin
            if (w_xfer) begin
                r_ptr <= (w_gnt == IW'(MN - 1)) ? '0 : w_gnt + IW'(1);
                r_lck <= 1'b0;
            end else if (sub_vld) begin
                // Hold the stalled request so a later, higher-priority
                // request cannot change the address under the subordinate.
                r_lck     <= 1'b1;
                r_lck_idx <= w_gnt;
            end
        end
    end

    if (DLY > 0) begin : g_pipe
        logic [DLY-1:0]         r_vld_pipe;
        logic [DLY-1:0][IW-1:0] r_idx_pipe;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld_pipe <= '0;
                r_idx_pipe <= '0;
            end else begin
                r_vld_pipe[0] <= w_xfer;
                if (w_xfer) r_idx_pipe[0] <= w_gnt;
                for (int k = 1; k < DLY; k++) begin
                    r_vld_pipe[k] <= r_vld_pipe[k-1];
                    r_idx_pipe[k] <= r_idx_pipe[k-1];
                end
            end
        end

        assign w_out_vld = r_vld_pipe[DLY-1];
        assign w_out_idx = r_idx_pipe[DLY-1];
    end else begin : g_nopipe
        // Zero-delay subordinate answers in the request cycle.
        assign w_out_vld = w_xfer;
        assign w_out_idx = w_gnt;
    end

    for (genvar i = 0; i < MN; i++) begin : g_mng
        assign mng_rdy[i] = w_xfer & (w_gnt == IW'(i));
        assign mng_err[i] = sub_err & w_out_vld & (w_out_idx == IW'(i));
    end

    // A locked manager must keep its request up until it is accepted.
    always @(posedge clk) begin
        if (rst_n && r_lck) assert (mng_vld[r_lck_idx]);
    end

endmodule
